vend_sequencer: RTL and testbench

VEND_SEQUENCER -- requirements
Module: vend_sequencer

---
 rtl/vend_pkg.sv | 53 +++++
 rtl/vend_credit.sv | 47 ++++
 rtl/vend_sequencer.sv | 142 ++++++++++++++
 tb/tb_vend_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer: state encoding,
// coin codes, credit sizing and the product price table.
package vend_pkg;

  localparam int CREDIT_W = 5;
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_CHANGE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } coin_e;

  localparam logic [CREDIT_W-1:0] VAL_NICKEL  = 5'd1;
  localparam logic [CREDIT_W-1:0] VAL_DIME    = 5'd2;
  localparam logic [CREDIT_W-1:0] VAL_QUARTER = 5'd5;

  localparam logic [CREDIT_W-1:0] PRICE_P0 = 5'd4;
  localparam logic [CREDIT_W-1:0] PRICE_P1 = 5'd5;
  localparam logic [CREDIT_W-1:0] PRICE_P2 = 5'd7;
  localparam logic [CREDIT_W-1:0] PRICE_P3 = 5'd10;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    logic [CREDIT_W-1:0] val;
    case (code)
      COIN_NICKEL:  val = VAL_NICKEL;
      COIN_DIME:    val = VAL_DIME;
      COIN_QUARTER: val = VAL_QUARTER;
      default:      val = 5'd0;
    endcase
    return val;
  endfunction

  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] id);
    logic [CREDIT_W-1:0] p;
    case (id)
      2'd0:    p = PRICE_P0;
      2'd1:    p = PRICE_P1;
      2'd2:    p = PRICE_P2;
      2'd3:    p = PRICE_P3;
      default: p = PRICE_P3;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/vend_credit.sv
// Credit register in nickel units with coin add, price/change subtract and
// the overflow check that decides whether an inserted coin can be kept.
module vend_credit
  import vend_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin_i,
  input  logic                add_en_i,
  input  logic                sub_en_i,
  input  logic [CREDIT_W-1:0] sub_amt_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic [CREDIT_W-1:0] credit_next_o,
  output logic                coin_fits_o
);

  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] credit_d;
  logic [CREDIT_W:0]   sum_s;

  // One extra bit on the sum so a wrap past 31 is seen as an overflow
  always_comb begin
    sum_s       = {1'b0, credit_q} + {1'b0, coin_value(coin_i)};
    coin_fits_o = (sum_s <= {1'b0, CREDIT_MAX});
    credit_d    = credit_q;
    if (sub_en_i) begin
      credit_d = credit_q - sub_amt_i;
    end else if (add_en_i && coin_fits_o) begin
      credit_d = sum_s[CREDIT_W-1:0];
    end else begin
      credit_d = credit_q;
    end
  end

  // Credit register
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= {CREDIT_W{1'b0}};
    end else begin
      credit_q <= credit_d;
    end
  end

  assign credit_o      = credit_q;
  assign credit_next_o = credit_d;

endmodule

// File: rtl/vend_sequencer.sv
// Vending sequencer: accepts coins, sells products, pays change one coin at a
// time over level handshakes. All outputs come straight from flops.
module vend_sequencer
  import vend_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                sel_vld,
  input  logic [1:0]          sel,
  input  logic                cancel,
  input  logic                disp_ack,
  input  logic                chg_ack,
  output logic                disp_req,
  output logic [1:0]          disp_id,
  output logic                chg_req,
  output logic                chg_dime,
  output logic                coin_rej,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  state_e state_q, state_d;
  logic [1:0] disp_id_q, disp_id_d;
  logic disp_req_q, disp_req_d;
  logic chg_req_q, chg_req_d;
  logic chg_dime_q, chg_dime_d;
  logic coin_rej_q, coin_rej_d;
  logic busy_q, busy_d;

  logic                add_en_s;
  logic                sub_en_s;
  logic [CREDIT_W-1:0] sub_amt_s;
  logic [CREDIT_W-1:0] credit_s;
  logic [CREDIT_W-1:0] credit_next_s;
  logic                coin_fits_s;
  logic                coin_nz_s;
  logic [CREDIT_W-1:0] price_s;
  logic [CREDIT_W-1:0] chg_amt_s;

  vend_credit u_credit (
    .clk           (clk),
    .rst           (rst),
    .coin_i        (coin),
    .add_en_i      (add_en_s),
    .sub_en_i      (sub_en_s),
    .sub_amt_i     (sub_amt_s),
    .credit_o      (credit_s),
    .credit_next_o (credit_next_s),
    .coin_fits_o   (coin_fits_s)
  );

  assign coin_nz_s = (coin != COIN_NONE);
  assign price_s   = price_of(sel);
  assign chg_amt_s = (credit_s >= VAL_DIME) ? VAL_DIME : VAL_NICKEL;

  // Next state and credit control; in IDLE cancel beats sel_vld beats coin
  always_comb begin
    state_d    = state_q;
    disp_id_d  = disp_id_q;
    add_en_s   = 1'b0;
    sub_en_s   = 1'b0;
    sub_amt_s  = {CREDIT_W{1'b0}};
    coin_rej_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cancel && (credit_s != {CREDIT_W{1'b0}})) begin
          state_d    = ST_CHANGE;
          coin_rej_d = coin_nz_s;
        end else if (sel_vld && (credit_s >= price_s)) begin
          state_d    = ST_DISPENSE;
          disp_id_d  = sel;
          sub_en_s   = 1'b1;
          sub_amt_s  = price_s;
          coin_rej_d = coin_nz_s;
        end else begin
          add_en_s   = coin_nz_s;
          coin_rej_d = coin_nz_s && !coin_fits_s;
        end
      end
      ST_DISPENSE: begin
        coin_rej_d = coin_nz_s;
        if (disp_ack) begin
          state_d = (credit_s != {CREDIT_W{1'b0}}) ? ST_CHANGE : ST_IDLE;
        end else begin
          state_d = ST_DISPENSE;
        end
      end
      ST_CHANGE: begin
        coin_rej_d = coin_nz_s;
        if (chg_ack) begin
          sub_en_s  = 1'b1;
          sub_amt_s = chg_amt_s;
          state_d   = (credit_s == chg_amt_s) ? ST_IDLE : ST_CHANGE;
        end else begin
          state_d = ST_CHANGE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from next state so every output is a flop
  always_comb begin
    disp_req_d = (state_d == ST_DISPENSE);
    chg_req_d  = (state_d == ST_CHANGE) && (credit_next_s != {CREDIT_W{1'b0}});
    chg_dime_d = chg_req_d && (credit_next_s >= VAL_DIME);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      disp_id_q  <= 2'd0;
      disp_req_q <= 1'b0;
      chg_req_q  <= 1'b0;
      chg_dime_q <= 1'b0;
      coin_rej_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      disp_id_q  <= disp_id_d;
      disp_req_q <= disp_req_d;
      chg_req_q  <= chg_req_d;
      chg_dime_q <= chg_dime_d;
      coin_rej_q <= coin_rej_d;
      busy_q     <= busy_d;
    end
  end

  assign disp_req = disp_req_q;
  assign disp_id  = disp_id_q;
  assign chg_req  = chg_req_q;
  assign chg_dime = chg_dime_q;
  assign coin_rej = coin_rej_q;
  assign credit   = credit_s;
  assign busy     = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Scenario bench for vend_sequencer: expected dispenses and change coins are
// queued as stimulus is applied and checked when the handshakes appear.
module tb_vend_sequencer;

  logic       clk;
  logic       rst;
  logic [1:0] coin;
  logic       sel_vld;
  logic [1:0] sel;
  logic       cancel;
  logic       disp_ack;
  logic       chg_ack;
  logic       disp_req;
  logic [1:0] disp_id;
  logic       chg_req;
  logic       chg_dime;
  logic       coin_rej;
  logic [4:0] credit;
  logic       busy;

  typedef struct packed {
    logic       dime;
    logic [4:0] credit_after;
  } chg_exp_t;

  logic [1:0] disp_q[$];
  chg_exp_t   chg_q[$];

  int checks = 0;
  int errors = 0;

  vend_sequencer dut (
    .clk(clk), .rst(rst), .coin(coin), .sel_vld(sel_vld), .sel(sel),
    .cancel(cancel), .disp_ack(disp_ack), .chg_ack(chg_ack),
    .disp_req(disp_req), .disp_id(disp_id), .chg_req(chg_req),
    .chg_dime(chg_dime), .coin_rej(coin_rej), .credit(credit), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_coin(input logic [1:0] c);
    coin = c;
    step();
    coin = 2'b00;
  endtask

  task automatic select(input logic [1:0] id);
    sel_vld = 1'b1;
    sel     = id;
    step();
    sel_vld = 1'b0;
  endtask

  task automatic push_change_from(input logic [4:0] start);
    logic [4:0] c;
    chg_exp_t   e;
    c = start;
    while (c != 5'd0) begin
      e.dime = (c >= 5'd2);
      c = c - (e.dime ? 5'd2 : 5'd1);
      e.credit_after = c;
      chg_q.push_back(e);
    end
  endtask

  task automatic serve_dispense();
    int n;
    logic [1:0] exp_id;
    n = 0;
    while (disp_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (disp_req !== 1'b1 || disp_q.size() == 0) begin
      errors++;
      $display("FAIL dispense_wait: disp_req=%b queued=%0d required disp_req=1", disp_req, disp_q.size());
    end else begin
      exp_id = disp_q.pop_front();
      checks++;
      if (disp_id !== exp_id) begin
        errors++;
        $display("FAIL disp_id: got %0d expected %0d", disp_id, exp_id);
      end
      disp_ack = 1'b1;
      step();
      disp_ack = 1'b0;
      checks++;
      if (disp_req !== 1'b0) begin
        errors++;
        $display("FAIL disp_req_drop: got %b expected 0", disp_req);
      end
    end
  endtask

  task automatic drain_change();
    int n;
    chg_exp_t e;
    while (chg_q.size() > 0) begin
      n = 0;
      while (chg_req !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      checks++;
      if (chg_req !== 1'b1 || disp_req !== 1'b0) begin
        errors++;
        $display("FAIL chg_req_wait: chg_req=%b disp_req=%b expected 1/0", chg_req, disp_req);
        chg_q.delete();
        break;
      end
      e = chg_q.pop_front();
      checks++;
      if (chg_dime !== e.dime) begin
        errors++;
        $display("FAIL chg_dime: got %b expected %b (credit %0d)", chg_dime, e.dime, credit);
      end
      chg_ack = 1'b1;
      step();
      chg_ack = 1'b0;
      checks++;
      if (credit !== e.credit_after) begin
        errors++;
        $display("FAIL chg_credit: got %0d expected %0d", credit, e.credit_after);
      end
    end
    checks++;
    if (chg_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL change_done: chg_req=%b busy=%b expected 0/0", chg_req, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; coin = 2'b11; sel_vld = 1'b1; sel = 2'd3; cancel = 1'b1;
    disp_ack = 1'b0; chg_ack = 1'b0;
    step();
    step();
    rst = 1'b0; coin = 2'b00; sel_vld = 1'b0; sel = 2'd0; cancel = 1'b0;
    checks++;
    if ({disp_req, chg_req, chg_dime, coin_rej, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {disp_req, chg_req, chg_dime, coin_rej, busy});
    end
    checks++;
    if (credit !== 5'd0 || disp_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_credit: credit=%0d disp_id=%0d expected 0/0", credit, disp_id);
    end
  endtask

  task automatic test_exact_price();
    for (int i = 0; i < 4; i++) drive_coin(2'b01);
    checks++;
    if (credit !== 5'd4) begin
      errors++;
      $display("FAIL exact_credit: got %0d expected 4", credit);
    end
    coin = 2'b10;
    select(2'd0);
    coin = 2'b00;
    disp_q.push_back(2'd0);
    checks++;
    if (credit !== 5'd0 || disp_req !== 1'b1 || coin_rej !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL exact_sell: credit=%0d disp_req=%b coin_rej=%b busy=%b expected 0/1/1/1",
               credit, disp_req, coin_rej, busy);
    end
    step();
    step();
    checks++;
    if (disp_req !== 1'b1 || chg_req !== 1'b0) begin
      errors++;
      $display("FAIL exact_hold: disp_req=%b chg_req=%b expected 1/0", disp_req, chg_req);
    end
    serve_dispense();
    checks++;
    if (busy !== 1'b0 || chg_req !== 1'b0 || credit !== 5'd0) begin
      errors++;
      $display("FAIL exact_idle: busy=%b chg_req=%b credit=%0d expected 0/0/0", busy, chg_req, credit);
    end
  endtask

  task automatic test_change_nickel();
    drive_coin(2'b10);
    drive_coin(2'b01);
    drive_coin(2'b10);
    checks++;
    if (credit !== 5'd5) begin
      errors++;
      $display("FAIL dnd_credit: got %0d expected 5", credit);
    end
    select(2'd0);
    disp_q.push_back(2'd0);
    push_change_from(5'd1);
    serve_dispense();
    drain_change();
  endtask

  task automatic test_cancel();
    drive_coin(2'b11);
    drive_coin(2'b10);
    cancel = 1'b1;
    coin   = 2'b01;
    step();
    cancel = 1'b0;
    coin   = 2'b00;
    checks++;
    if (credit !== 5'd7 || coin_rej !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cancel_entry: credit=%0d coin_rej=%b busy=%b expected 7/1/1", credit, coin_rej, busy);
    end
    push_change_from(5'd7);
    drain_change();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) drive_coin(2'b11);
    drive_coin(2'b10);
    checks++;
    if (credit !== 5'd30 || coin_rej !== 1'b1) begin
      errors++;
      $display("FAIL overflow_rej: credit=%0d coin_rej=%b expected 30/1", credit, coin_rej);
    end
    step();
    checks++;
    if (coin_rej !== 1'b0) begin
      errors++;
      $display("FAIL overflow_pulse: coin_rej=%b expected 0", coin_rej);
    end
    drive_coin(2'b01);
    checks++;
    if (credit !== 5'd31 || coin_rej !== 1'b0) begin
      errors++;
      $display("FAIL overflow_max: credit=%0d coin_rej=%b expected 31/0", credit, coin_rej);
    end
    select(2'd3);
    disp_q.push_back(2'd3);
    drive_coin(2'b10);
    checks++;
    if (credit !== 5'd21 || coin_rej !== 1'b1 || disp_req !== 1'b1) begin
      errors++;
      $display("FAIL busy_coin_rej: credit=%0d coin_rej=%b disp_req=%b expected 21/1/1",
               credit, coin_rej, disp_req);
    end
    serve_dispense();
    push_change_from(5'd21);
    drain_change();
  endtask

  task automatic test_insufficient();
    drive_coin(2'b10);
    drive_coin(2'b10);
    disp_ack = 1'b1;
    chg_ack  = 1'b1;
    select(2'd3);
    disp_ack = 1'b0;
    chg_ack  = 1'b0;
    checks++;
    if (credit !== 5'd4 || busy !== 1'b0 || disp_req !== 1'b0) begin
      errors++;
      $display("FAIL short_credit: credit=%0d busy=%b disp_req=%b expected 4/0/0", credit, busy, disp_req);
    end
    coin = 2'b01;
    select(2'd3);
    coin = 2'b00;
    checks++;
    if (credit !== 5'd5 || coin_rej !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL short_coin: credit=%0d coin_rej=%b busy=%b expected 5/0/0", credit, coin_rej, busy);
    end
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    push_change_from(5'd5);
    drain_change();
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 4; i++) drive_coin(2'b10);
    select(2'd2);
    disp_q.push_back(2'd2);
    checks++;
    if (disp_req !== 1'b1 || disp_id !== 2'd2 || credit !== 5'd1) begin
      errors++;
      $display("FAIL abort_setup: disp_req=%b disp_id=%0d credit=%0d expected 1/2/1", disp_req, disp_id, credit);
    end
    rst  = 1'b1;
    coin = 2'b10;
    step();
    rst  = 1'b0;
    coin = 2'b00;
    disp_q.delete();
    checks++;
    if ({disp_req, chg_req, chg_dime, coin_rej, busy} !== 5'b0 || credit !== 5'd0 || disp_id !== 2'd0) begin
      errors++;
      $display("FAIL abort_dispense: flags=%b credit=%0d disp_id=%0d expected 00000/0/0",
               {disp_req, chg_req, chg_dime, coin_rej, busy}, credit, disp_id);
    end
    drive_coin(2'b10);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    checks++;
    if (chg_req !== 1'b1 || chg_dime !== 1'b1) begin
      errors++;
      $display("FAIL abort_change_setup: chg_req=%b chg_dime=%b expected 1/1", chg_req, chg_dime);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({disp_req, chg_req, chg_dime, coin_rej, busy} !== 5'b0 || credit !== 5'd0) begin
      errors++;
      $display("FAIL abort_change: flags=%b credit=%0d expected 00000/0",
               {disp_req, chg_req, chg_dime, coin_rej, busy}, credit);
    end
    step();
    checks++;
    if (busy !== 1'b0 || chg_req !== 1'b0) begin
      errors++;
      $display("FAIL abort_settle: busy=%b chg_req=%b expected 0/0", busy, chg_req);
    end
  endtask

  initial begin
    test_reset();
    test_exact_price();
    test_change_nickel();
    test_cancel();
    test_overflow();
    test_insufficient();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
